// File: rtl/mem_access_unit.sv
// Data-memory access stage: runs one load or store per request over a
// req/ack port, aligns store data into byte lanes, extracts and extends
// load data, stalls the pipeline while busy, and reports faults.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  // Counter only has to reach TIMEOUT_CYCLES-1 before the timeout fires.
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [29:0] waddr_q, waddr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] load_data_q, load_data_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;

  // Request decode for the instruction currently presented in IDLE.
  logic        req, illegal, misaligned, start;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_be;
  logic [31:0] rshift, ext_data;

  // Decode legality/alignment and format store data into byte lanes.
  always_comb begin
    req        = mem_read | mem_write;
    illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                 (mem_write && funct3[2]);
    misaligned = !illegal &&
                 (((funct3[1:0] == 2'b01) && address[0]) ||
                  ((funct3 == 3'b010) && (address[1:0] != 2'b00)));
    start      = req && !illegal && !misaligned;
    fmt_wdata  = 32'h0;
    fmt_be     = 4'b1111;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          fmt_wdata = {4{store_data[7:0]}};
          fmt_be    = 4'b0001 << address[1:0];
        end
        2'b01: begin
          fmt_wdata = {2{store_data[15:0]}};
          fmt_be    = address[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          fmt_wdata = store_data;
          fmt_be    = 4'b1111;
        end
      endcase
    end
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    rshift = dmem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  ext_data = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  ext_data = lane_q[1] ? {{16{dmem_rdata[31]}}, dmem_rdata[31:16]}
                                    : {{16{dmem_rdata[15]}}, dmem_rdata[15:0]};
      3'b100:  ext_data = {24'h0, rshift[7:0]};
      3'b101:  ext_data = lane_q[1] ? {16'h0, dmem_rdata[31:16]}
                                    : {16'h0, dmem_rdata[15:0]};
      default: ext_data = dmem_rdata;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      waddr_q     <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      funct3_q    <= '0;
      lane_q      <= '0;
      load_data_q <= '0;
      fault_q     <= 1'b0;
      cause_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      waddr_q     <= waddr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
      cause_q     <= cause_d;
    end
  end

  // Next-state logic: launch, wait for ack or timeout, then one RESP cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    waddr_d     = waddr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    load_data_d = load_data_q;
    fault_d     = 1'b0;
    cause_d     = 2'b00;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req && illegal) begin
          fault_d = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end else if (req && misaligned) begin
          fault_d = 1'b1;
          cause_d = CAUSE_MISALIGN;
        end else if (start) begin
          state_d  = ACCESS;
          waddr_d  = address[31:2];
          we_d     = mem_write;
          wdata_d  = fmt_wdata;
          be_d     = fmt_be;
          funct3_d = funct3;
          lane_d   = address[1:0];
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          // Ack beats a timeout landing in the same cycle.
          state_d = RESP;
          cnt_d   = '0;
          if (!we_q) load_data_d = ext_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        // Inputs still show the serviced instruction; ignore them.
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: memory port is quiet outside ACCESS.
  always_comb begin
    busy        = (state_q == ACCESS) || ((state_q == IDLE) && start);
    dmem_req    = (state_q == ACCESS);
    dmem_we     = dmem_req & we_q;
    dmem_addr   = dmem_req ? {waddr_q, 2'b00} : 32'h0;
    dmem_wdata  = dmem_req ? wdata_q : 32'h0;
    dmem_be     = dmem_req ? be_q : 4'b0000;
    load_valid  = (state_q == RESP) && !we_q;
    load_data   = load_data_q;
    fault       = fault_q;
    fault_cause = cause_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with TIMEOUT_CYCLES=4.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] address, store_data;
  logic        busy, load_valid, fault;
  logic [31:0] load_data;
  logic [1:0]  fault_cause;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int n_chk = 0;
  int n_pass = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .address(address), .store_data(store_data),
    .busy(busy), .load_data(load_data), .load_valid(load_valid),
    .fault(fault), .fault_cause(fault_cause), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    mem_read = rd; mem_write = wr; funct3 = f3; address = a; store_data = sd;
  endtask

  task automatic clear_req();
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Load acked in the first ACCESS cycle.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rd, input logic [31:0] exp);
    tick(); issue(1'b1, 1'b0, f3, a, 32'h0);
    @(negedge clk); chk({tag, "_busy0"}, busy, 1); chk({tag, "_req0"}, dmem_req, 0);
    tick(); dmem_ack = 1'b1; dmem_rdata = rd;
    @(negedge clk);
    chk({tag, "_req"}, dmem_req, 1);
    chk({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
    chk({tag, "_be"}, dmem_be, 4'hF);
    chk({tag, "_we"}, dmem_we, 0);
    tick(); dmem_ack = 1'b0; clear_req();
    @(negedge clk);
    chk({tag, "_lv"}, load_valid, 1);
    chk({tag, "_data"}, load_data, exp);
    chk({tag, "_busy"}, busy, 0);
    tick();
    @(negedge clk); chk({tag, "_lv_off"}, load_valid, 0);
  endtask

  // Store acked in the first ACCESS cycle.
  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] exp_wd,
                           input logic [3:0] exp_be);
    tick(); issue(1'b0, 1'b1, f3, a, sd);
    @(negedge clk); chk({tag, "_busy0"}, busy, 1);
    tick(); dmem_ack = 1'b1;
    @(negedge clk);
    chk({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
    chk({tag, "_wdata"}, dmem_wdata, exp_wd);
    chk({tag, "_be"}, dmem_be, exp_be);
    chk({tag, "_we"}, dmem_we, 1);
    tick(); dmem_ack = 1'b0; clear_req();
    @(negedge clk);
    chk({tag, "_lv"}, load_valid, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int reqs;
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick(); tick();
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_req", dmem_req, 0);
    chk("rst_ld", load_data, 0); chk("rst_fault", fault, 0);
    chk("rst_cause", fault_cause, 0); chk("rst_lv", load_valid, 0);
    tick(); reset = 1'b0;

    run_load("lw", 3'b010, 32'h0000_1004, 32'hDEADBEEF, 32'hDEADBEEF);
    run_load("lb", 3'b000, 32'h0000_2003, 32'h80123456, 32'hFFFFFF80);
    run_load("lbu", 3'b100, 32'h0000_2003, 32'h80123456, 32'h00000080);
    run_load("lh", 3'b001, 32'h0000_2002, 32'h80123456, 32'hFFFF8012);
    run_load("lhu", 3'b101, 32'h0000_2000, 32'h80123456, 32'h00003456);

    // SH with three wait cycles; ack in the 4th ACCESS cycle.
    tick(); issue(1'b0, 1'b1, 3'b001, 32'h0000_1002, 32'h0000BEEF);
    @(negedge clk); chk("sh_busy0", busy, 1);
    reqs = 0;
    for (int k = 1; k <= 4; k++) begin
      tick(); if (k == 4) dmem_ack = 1'b1;
      @(negedge clk);
      if (dmem_req) reqs++;
      if (k == 2) begin
        chk("sh_addr", dmem_addr, 32'h0000_1000);
        chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
        chk("sh_be", dmem_be, 4'b1100);
        chk("sh_we", dmem_we, 1);
      end
    end
    chk("sh_req_cycles", reqs, 4);
    tick(); dmem_ack = 1'b0; clear_req();
    @(negedge clk);
    chk("sh_lv", load_valid, 0); chk("sh_req_off", dmem_req, 0);
    chk("sh_ld_kept", load_data, 32'h00003456);

    run_store("sb", 3'b000, 32'h0000_2001, 32'h000000AB, 32'hABABABAB, 4'b0010);

    // Misaligned LW.
    tick(); issue(1'b1, 1'b0, 3'b010, 32'h0000_1001, 32'h0);
    @(negedge clk); chk("mis_busy", busy, 0); chk("mis_req", dmem_req, 0);
    tick(); clear_req();
    @(negedge clk);
    chk("mis_fault", fault, 1); chk("mis_cause", fault_cause, 2'b01);
    chk("mis_req1", dmem_req, 0);
    tick();
    @(negedge clk); chk("mis_fault_off", fault, 0); chk("mis_cause_off", fault_cause, 0);

    // Store with an unsigned width is illegal.
    tick(); issue(1'b0, 1'b1, 3'b100, 32'h0000_1000, 32'h1);
    @(negedge clk); chk("ill_busy", busy, 0);
    tick(); clear_req();
    @(negedge clk);
    chk("ill_fault", fault, 1); chk("ill_cause", fault_cause, 2'b11);
    chk("ill_req", dmem_req, 0);

    // Timeout: no ack for 4 cycles.
    tick(); issue(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0);
    reqs = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      @(negedge clk);
      if (dmem_req) reqs++;
      chk("to_nofault", fault, 0);
    end
    chk("to_req_cycles", reqs, 4);
    tick(); clear_req();
    @(negedge clk);
    chk("to_fault", fault, 1); chk("to_cause", fault_cause, 2'b10);
    chk("to_req_off", dmem_req, 0); chk("to_busy", busy, 0);
    chk("to_lv", load_valid, 0);

    // Ack in the 4th cycle wins over the timeout.
    tick(); issue(1'b1, 1'b0, 3'b010, 32'h0000_3004, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) begin dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D; end
    end
    tick(); dmem_ack = 1'b0; clear_req();
    @(negedge clk);
    chk("late_lv", load_valid, 1); chk("late_fault", fault, 0);
    chk("late_data", load_data, 32'hCAFEF00D);
    tick();
    @(negedge clk); chk("late_fault2", fault, 0);

    // Reset during the 2nd ACCESS cycle.
    tick(); issue(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0);
    tick(); tick(); reset = 1'b1;
    @(negedge clk); chk("mr_req_before", dmem_req, 1);
    tick(); reset = 1'b0; clear_req();
    @(negedge clk);
    chk("mr_req", dmem_req, 0); chk("mr_busy", busy, 0);
    chk("mr_lv", load_valid, 0); chk("mr_fault", fault, 0);
    chk("mr_ld", load_data, 0);

    run_store("sw", 3'b010, 32'h0000_5008, 32'h12345678, 32'h12345678, 4'b1111);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Data-memory access stage directly downstream of the execute-stage ALU. It consumes the ALU's computed effective address plus the store operand, then runs one load or store transaction on the data-memory port using a req/ack handshake. For stores it aligns the data and generates byte enables; for loads it extracts the addressed bytes and sign- or zero-extends them. It raises a stall to the pipeline while a transaction is in flight, and reports misalignment, illegal-width and bus-timeout faults.

Parameters:
TIMEOUT_CYCLES, 16, max cycles dmem_req is held without dmem_ack before a bus fault (must be >= 1)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
mem_read  input  1  load request from EX/MEM
mem_write  input  1  store request from EX/MEM; wins if both mem_read and mem_write are high
funct3  input  3  access width: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are load-only)
address  input  32  effective address (ALU result)
store_data  input  32  rs2 value for stores
busy  output  1  stall request to pipeline
load_data  output  32  extended load result
load_valid  output  1  one-cycle pulse when load_data is updated
fault  output  1  one-cycle fault pulse
fault_cause  output  2  01 misaligned, 10 bus timeout, 11 illegal funct3; 00 when fault=0
dmem_req  output  1  memory request
dmem_we  output  1  1 = write
dmem_addr  output  32  word address, always {addr[31:2],2'b00}
dmem_wdata  output  32  lane-replicated write data
dmem_be  output  4  byte enables
dmem_ack  input  1  memory completion; rdata is valid in the same cycle
dmem_rdata  input  32  read data word

Behaviour:
- State machine: IDLE, ACCESS, RESP.
- Reset: state IDLE, timeout counter 0. All outputs 0, including load_data and fault_cause. Reset mid-ACCESS drops dmem_req at the next edge; no fault, no load_valid.
- IDLE, no request: busy=0, dmem_req=0.
- IDLE, request present: check funct3 first.
  - Illegal funct3 is any of 011/110/111, or 100/101 with a store. Result: fault=1, cause 11, next cycle.
  - Misaligned is H/HU with addr[0]=1, or W with addr[1:0]!=0. Result: fault=1, cause 01, next cycle.
  - In both fault cases: no memory request, busy=0, stay IDLE.
  - Otherwise (legal, aligned): busy=1 combinationally in this cycle. Latch addr/we/wdata/be/funct3/lane and go to ACCESS.
- ACCESS:
  - dmem_req=1, busy=1. dmem_addr/we/wdata/be are registered and stable until ack.
  - Counter increments each cycle with ack=0.
  - ack=1: capture the extended load data, go to RESP.
  - No ack in the TIMEOUT_CYCLES-th ACCESS cycle: next cycle fault=1 with cause 10, dmem_req=0, state IDLE. If ack arrives in that same cycle, the ack wins.
- RESP:
  - busy=0. load_valid=1 for a load only; the store completes silently.
  - Request inputs are ignored: they still show the stalled, already-serviced instruction.
  - Next state is IDLE.
- Latency: request at cycle 0 → dmem_req cycles 1..n → ack at cycle n → RESP/load_valid at n+1. busy is high over cycles 0..n.
- Store formatting:
  - SB: wdata={4{data[7:0]}}, be=0001<<addr[1:0].
  - SH: wdata={2{data[15:0]}}, be=0011 (addr[1]=0) or 1100.
  - SW: wdata=data, be=1111.
- Loads: dmem_be=1111, dmem_wdata=0.
- Load extraction: byte lane addr[1:0], half lane addr[1]. B/H sign-extend; BU/HU zero-extend; W passes the word through.
- load_data holds its value until the next completed load. Stores and faults leave it unchanged.
- dmem_ack outside ACCESS is ignored. fault and load_valid are never high in the same cycle.

Test Plan:
- LW addr 0x0000_1004, ack in first ACCESS cycle, rdata 0xDEADBEEF → dmem_addr 0x1004, be 1111; busy high 2 cycles; load_valid pulse with load_data 0xDEADBEEF.
- LB addr 0x2003, rdata 0x80123456 → load_data 0xFFFFFF80. LBU same → 0x00000080. LH addr 0x2002 → 0xFFFF8012.
- SH addr 0x1002, store_data 0x0000BEEF, ack after 3 wait cycles → dmem_addr 0x1000, wdata 0xBEEFBEEF, be 1100, we=1; req held 4 cycles; no load_valid.
- LW addr 0x1001 → fault cause 01 next cycle, dmem_req never asserted, busy=0. Store with funct3=100 → fault cause 11.
- TIMEOUT_CYCLES=4, LW, ack never arrives → dmem_req high exactly 4 cycles, then fault cause 10, state IDLE. Repeat with ack in the 4th cycle → normal load_valid, no fault.
- Assert reset in the 2nd ACCESS cycle → dmem_req=0, busy=0, load_valid=0, fault=0 after the edge; a subsequent SW completes normally.
